hex_mem_arbiter: RTL and testbench

- Shares the single memory port between three requesters: the binary loader (L), processor instruction fetch (F) and processor data access (D).
- Sits between the processor, the loader and the memory in the top level. Sequences a boot phase, in which only the loader writes, then a run phase with round-robin F/D arbitration.
- Pipelined: one memory op per cycle, up to RD_LATENCY+1 reads in flight, and responses are tagged back to their owner.

---
 rtl/hex_mem_arbiter.sv | 81 ++++++++
 tb/tb_hex_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_mem_arbiter.sv
// hex_mem_arbiter: shares one pipelined memory port between the loader (boot phase) and
// the processor's fetch/data ports (run phase, round-robin), routing tagged read responses back.
module hex_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_l_valid,
  output logic              o_l_ready,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [DATA_W-1:0] i_l_wdata,
  input  logic              i_l_done,
  input  logic              i_f_valid,
  output logic              o_f_ready,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_rvalid,
  output logic [DATA_W-1:0] o_f_rdata,
  input  logic              i_d_valid,
  output logic              o_d_ready,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_m_valid,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata,
  output logic              o_running
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state;
  logic last_f;
  logic gnt_f, gnt_d, issue;
  logic [RD_LATENCY:0] tag_v, tag_d;
  // last_f set means fetch won most recently, so data wins the next tie
  always_comb begin
    gnt_d = i_d_valid && (!i_f_valid || last_f);
    gnt_f = i_f_valid && !gnt_d;
  end
  assign o_l_ready = i_rst && state == BOOT && i_l_valid;
  assign o_f_ready = state == RUN && gnt_f;
  assign o_d_ready = state == RUN && gnt_d;
  assign o_running = state == RUN;
  assign issue = o_l_ready || o_f_ready || o_d_ready;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= BOOT;
      last_f     <= 1'b1;
      o_m_valid  <= 1'b0;
      o_m_we     <= 1'b0;
      o_m_addr   <= '0;
      o_m_wdata  <= '0;
      tag_v      <= '0;
      tag_d      <= '0;
      o_f_rvalid <= 1'b0;
      o_f_rdata  <= '0;
      o_d_rvalid <= 1'b0;
      o_d_rdata  <= '0;
    end else begin
      if (state == BOOT && i_l_done) state <= RUN;
      if (o_f_ready || o_d_ready) last_f <= o_f_ready;
      o_m_valid <= issue;
      o_m_we    <= o_l_ready || (o_d_ready && i_d_we);
      if (issue) begin
        o_m_addr  <= o_l_ready ? i_l_addr : o_f_ready ? i_f_addr : i_d_addr;
        o_m_wdata <= o_l_ready ? i_l_wdata : i_d_wdata;
      end
      // tag[k] lines up with the op issued k cycles ago; the oldest meets i_m_rdata
      tag_v <= {tag_v[RD_LATENCY-1:0], o_f_ready || (o_d_ready && !i_d_we)};
      tag_d <= {tag_d[RD_LATENCY-1:0], o_d_ready};
      o_f_rvalid <= tag_v[RD_LATENCY] && !tag_d[RD_LATENCY];
      o_d_rvalid <= tag_v[RD_LATENCY] && tag_d[RD_LATENCY];
      if (tag_v[RD_LATENCY] && !tag_d[RD_LATENCY]) o_f_rdata <= i_m_rdata;
      if (tag_v[RD_LATENCY] && tag_d[RD_LATENCY]) o_d_rdata <= i_m_rdata;
    end
  end
endmodule

// File: tb/tb_hex_mem_arbiter.sv
// tb_hex_mem_arbiter: checks two arbiter instances (read latency 1 and 3) against a
// cycle-level reference model of boot/run grants and tagged read responses.
module tb_hex_mem_arbiter;
  logic clk, rst;
  logic l_v, l_done, f_v, d_v, d_we;
  logic [31:0] l_addr, l_wd, f_addr, d_addr, d_wd;
  logic [1:0] l_rdy, f_rdy, d_rdy, f_rv, d_rv, m_v, m_we, run_o;
  logic [31:0] f_rd[2], d_rd[2], m_addr[2], m_wd[2], m_rd[2];
  logic [31:0] p1;
  logic [2:0][31:0] p3;
  int nchk, nbad, ecnt;
  bit run, last_f, em_v, em_we;
  logic [31:0] em_addr, em_wd, lf[2], ld[2];
  bit fv[2][1024], dv[2][1024];
  logic [31:0] fd[2][1024], dd[2][1024];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h4) ? 32'h12345678 : a + 32'h100;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    hex_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(g == 0 ? 1 : 3)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_l_valid(l_v), .o_l_ready(l_rdy[g]), .i_l_addr(l_addr), .i_l_wdata(l_wd), .i_l_done(l_done),
      .i_f_valid(f_v), .o_f_ready(f_rdy[g]), .i_f_addr(f_addr), .o_f_rvalid(f_rv[g]), .o_f_rdata(f_rd[g]),
      .i_d_valid(d_v), .o_d_ready(d_rdy[g]), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wd),
      .o_d_rvalid(d_rv[g]), .o_d_rdata(d_rd[g]),
      .o_m_valid(m_v[g]), .o_m_we(m_we[g]), .o_m_addr(m_addr[g]), .o_m_wdata(m_wd[g]),
      .i_m_rdata(m_rd[g]), .o_running(run_o[g])
    );
  end

  // memory environment: read-only contents, fixed latency per instance
  always @(posedge clk) begin
    p1 <= mem_fn(m_addr[0]);
    p3 <= {p3[1:0], mem_fn(m_addr[1])};
  end
  assign m_rd[0] = p1;
  assign m_rd[1] = p3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    l_v = 0; l_done = 0; f_v = 0; d_v = 0; d_we = 0;
    l_addr = 0; l_wd = 0; f_addr = 0; d_addr = 0; d_wd = 0;
  endtask

  task automatic model_reset();
    run = 0; last_f = 1; em_v = 0; em_we = 0; em_addr = 0; em_wd = 0;
    for (int k = 0; k < 2; k++) begin
      lf[k] = 0; ld[k] = 0;
      for (int i = 0; i < 1024; i++) begin fv[k][i] = 0; dv[k][i] = 0; end
    end
  endtask

  // one clock: compare both instances against the model mid-cycle, then advance the model
  task automatic tick();
    bit gf, gd, lg;
    int due;
    @(negedge clk);
    if (ecnt > 1000) begin
      $display("FAIL cycle_budget got %0d want <=1000", ecnt);
      $fatal(1);
    end
    lg = !run && l_v;
    gd = run && d_v && (!f_v || last_f);
    gf = run && f_v && !gd;
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if ({l_rdy[k], f_rdy[k], d_rdy[k]} !== {lg, gf, gd}) begin
        nbad++; $display("FAIL ready_lfd dut%0d cyc%0d got %b want %b", k, ecnt, {l_rdy[k], f_rdy[k], d_rdy[k]}, {lg, gf, gd});
      end
      nchk++;
      if ({m_v[k], run_o[k]} !== {em_v, run}) begin
        nbad++; $display("FAIL mvalid_running dut%0d cyc%0d got %b want %b", k, ecnt, {m_v[k], run_o[k]}, {em_v, run});
      end
      if (em_v) begin
        nchk++;
        if ({m_we[k], m_addr[k]} !== {em_we, em_addr}) begin
          nbad++; $display("FAIL m_we_addr dut%0d cyc%0d got %b/%h want %b/%h", k, ecnt, m_we[k], m_addr[k], em_we, em_addr);
        end
      end
      if (em_v && em_we) begin
        nchk++;
        if (m_wd[k] !== em_wd) begin
          nbad++; $display("FAIL m_wdata dut%0d cyc%0d got %h want %h", k, ecnt, m_wd[k], em_wd);
        end
      end
      nchk++;
      if ({f_rv[k], f_rd[k]} !== {fv[k][ecnt], lf[k]}) begin
        nbad++; $display("FAIL f_resp dut%0d cyc%0d got %b/%h want %b/%h", k, ecnt, f_rv[k], f_rd[k], fv[k][ecnt], lf[k]);
      end
      nchk++;
      if ({d_rv[k], d_rd[k]} !== {dv[k][ecnt], ld[k]}) begin
        nbad++; $display("FAIL d_resp dut%0d cyc%0d got %b/%h want %b/%h", k, ecnt, d_rv[k], d_rd[k], dv[k][ecnt], ld[k]);
      end
    end
    @(posedge clk);
    ecnt++;
    em_v = lg | gf | gd;
    em_we = lg | (gd & d_we);
    em_addr = lg ? l_addr : gf ? f_addr : d_addr;
    em_wd = lg ? l_wd : d_wd;
    if (gf | gd) last_f = gf;
    if (!run && l_done) run = 1;
    for (int k = 0; k < 2; k++) begin
      due = ecnt + (k == 0 ? 1 : 3) + 1;
      if (gf) begin fv[k][due] = 1; fd[k][due] = mem_fn(f_addr); end
      if (gd && !d_we) begin dv[k][due] = 1; dd[k][due] = mem_fn(d_addr); end
      if (fv[k][ecnt]) lf[k] = fd[k][ecnt];
      if (dv[k][ecnt]) ld[k] = dd[k][ecnt];
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if ({l_rdy[k], f_rdy[k], d_rdy[k], f_rv[k], d_rv[k], m_v[k], m_we[k], run_o[k]} !== 8'h0 ||
          m_addr[k] !== 0 || m_wd[k] !== 0 || f_rd[k] !== 0 || d_rd[k] !== 0) begin
        nbad++; $display("FAIL reset_state dut%0d got flags %b want 0", k,
          {l_rdy[k], f_rdy[k], d_rdy[k], f_rv[k], d_rv[k], m_v[k], m_we[k], run_o[k]});
      end
    end
    model_reset();
    rst = 1;
  endtask

  task automatic test_boot_write();
    l_v = 1; l_addr = 32'h10; l_wd = 32'hDEADBEEF; f_v = 1;
    #1;
    nchk++;
    if ({l_rdy[0], f_rdy[0]} !== 2'b10) begin
      nbad++; $display("FAIL boot_ready got %b want 10", {l_rdy[0], f_rdy[0]});
    end
    tick();
    nchk++;
    if ({m_v[0], m_we[0]} !== 2'b11 || m_addr[0] !== 32'h10 || m_wd[0] !== 32'hDEADBEEF) begin
      nbad++; $display("FAIL boot_issue got %b/%h/%h want 11/00000010/deadbeef", {m_v[0], m_we[0]}, m_addr[0], m_wd[0]);
    end
    for (int i = 0; i < 12; i++) begin
      l_v = 1'($urandom); f_v = 1'($urandom); d_v = 1'($urandom); d_we = 1'($urandom);
      l_addr = $urandom & 32'hff; l_wd = $urandom; f_addr = $urandom & 32'hf; d_addr = $urandom & 32'hf;
      tick();
    end
    idle();
  endtask

  task automatic test_boot_exit();
    l_v = 1; l_done = 1; l_addr = 32'h44; l_wd = 32'h5555AAAA;
    tick();
    l_done = 0;
    nchk++;
    if ({run_o[0], m_v[0], m_we[0]} !== 3'b111 || m_addr[0] !== 32'h44) begin
      nbad++; $display("FAIL boot_exit got %b/%h want 111/00000044", {run_o[0], m_v[0], m_we[0]}, m_addr[0]);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++;
      if (l_rdy !== 2'b00) begin
        nbad++; $display("FAIL loader_stall got %b want 00", l_rdy);
      end
      l_done = 1'(i == 2);
      tick();
    end
    idle();
  endtask

  task automatic test_fetch();
    f_v = 1; f_addr = 32'h4;
    tick();
    idle();
    repeat (2) tick();
    nchk++;
    if ({f_rv[0], d_rv[0]} !== 2'b10 || f_rd[0] !== 32'h12345678) begin
      nbad++; $display("FAIL fetch_lat1 got %b/%h want 10/12345678", {f_rv[0], d_rv[0]}, f_rd[0]);
    end
    tick();
    nchk++;
    if (f_rv[0] !== 1'b0) begin
      nbad++; $display("FAIL fetch_pulse got %b want 0", f_rv[0]);
    end
    tick();
    nchk++;
    if (f_rv[1] !== 1'b1 || f_rd[1] !== 32'h12345678) begin
      nbad++; $display("FAIL fetch_lat3 got %b/%h want 1/12345678", f_rv[1], f_rd[1]);
    end
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    f_v = 1; d_v = 1; d_we = 0; f_addr = 32'h20; d_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++;
      if ({f_rdy[0], d_rdy[0]} !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin
        nbad++; $display("FAIL rr_grant%0d got %b want %b", i, {f_rdy[0], d_rdy[0]}, (i % 2 == 0 ? 2'b01 : 2'b10));
      end
      tick();
      nchk++;
      if (m_addr[0] !== (i % 2 == 0 ? 32'h30 : 32'h20)) begin
        nbad++; $display("FAIL rr_addr%0d got %h want %h", i, m_addr[0], (i % 2 == 0 ? 32'h30 : 32'h20));
      end
    end
    idle();
    repeat (6) tick();
  endtask

  task automatic test_pipelined();
    d_v = 1; d_we = 0;
    for (int i = 0; i < 4; i++) begin
      d_addr = i;
      tick();
    end
    d_we = 1; d_addr = 32'h9; d_wd = $urandom;
    tick();
    idle();
    for (int j = 0; j < 4; j++) begin
      nchk++;
      if (d_rv[1] !== 1'b1 || d_rd[1] !== 32'h100 + j) begin
        nbad++; $display("FAIL pipe_rd%0d got %b/%h want 1/%h", j, d_rv[1], d_rd[1], 32'h100 + j);
      end
      tick();
    end
    nchk++;
    if (d_rv[1] !== 1'b0) begin
      nbad++; $display("FAIL pipe_write_rvalid got %b want 0", d_rv[1]);
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) begin
      l_v = 1'($urandom); f_v = 1'($urandom); d_v = 1'($urandom); d_we = ($urandom_range(0, 3) == 0);
      f_addr = $urandom & 32'hf; d_addr = $urandom & 32'hf; d_wd = $urandom; l_wd = $urandom;
      tick();
    end
    idle();
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    f_v = 1; f_addr = 32'h7;
    tick();
    l_v = 1; d_v = 1;
    @(negedge clk);
    rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if ({l_rdy[k], f_rdy[k], d_rdy[k], f_rv[k], d_rv[k], m_v[k], m_we[k], run_o[k]} !== 8'h0 ||
          m_addr[k] !== 0 || m_wd[k] !== 0) begin
        nbad++; $display("FAIL async_reset dut%0d got flags %b want 0", k,
          {l_rdy[k], f_rdy[k], d_rdy[k], f_rv[k], d_rv[k], m_v[k], m_we[k], run_o[k]});
      end
    end
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    repeat (6) tick();
    nchk++;
    if (run_o !== 2'b00) begin
      nbad++; $display("FAIL reset_boot got %b want 00", run_o);
    end
    l_v = 1; l_addr = 32'h3; l_wd = 32'hCAFEF00D;
    tick();
    idle();
    repeat (2) tick();
  endtask

  initial begin
    nchk = 0; nbad = 0; ecnt = 0;
    model_reset();
    test_reset();
    test_boot_write();
    test_boot_exit();
    test_fetch();
    test_round_robin();
    test_pipelined();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
